// File: rtl/inbus_pkg.sv
// Shared definitions for the inbus receive port: bus widths, register
// offsets relative to BASE, STATUS bit positions and a count formatter.
package inbus_pkg;

  localparam int INBUS_AW = 8;
  localparam int INBUS_DW = 8;

  // Register offsets relative to BASE; REG_NONE marks an undecoded address.
  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_COUNT  = 2'd2,
    REG_NONE   = 2'd3
  } reg_sel_e;

  // STATUS register bit positions.
  localparam int ST_NONEMPTY = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_OVF      = 2;

  // Formats a zero-extended FIFO count as a bus byte. A 256-entry FIFO can
  // hold one more entry than a byte can express, so the value saturates.
  function automatic logic [INBUS_DW-1:0] count_to_byte(input logic [15:0] cnt);
    if (cnt > 16'd255) begin
      return 8'hFF;
    end
    return cnt[INBUS_DW-1:0];
  endfunction

endpackage

// File: rtl/inbus_rx_fifo.sv
// Byte FIFO for the inbus receive port. Head data is read combinationally
// so the top level can capture it in the same cycle a pop is requested.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is ignored (the caller tracks the overflow).
module inbus_rx_fifo
  import inbus_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  logic [INBUS_DW-1:0] din_i,
  input  logic                pop_i,
  output logic [INBUS_DW-1:0] dout_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [AW:0]         count_o
);

  logic [INBUS_DW-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q,  count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/inbus_rx_port.sv
// Inbus slave exposing a receive FIFO as three registers at BASE..BASE+2
// (DATA pops the head, STATUS = {ovf, full, nonempty}, COUNT = occupancy).
// Each access is two cycles of inbus_re; only the first cycle has side
// effects and loads inbus_data, which holds until the next access starts.
// Undecoded addresses read 8'h00 so several slaves can be OR-combined.
// Optional build macro INBUS_RX_IRQ_EN adds a registered rx_irq output.
module inbus_rx_port
  import inbus_pkg::*;
#(
  parameter logic [INBUS_AW-1:0] BASE  = 8'h10,
  parameter int                  DEPTH = 8,
  parameter int                  AW    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INBUS_AW-1:0] inbus_addr,
  input  logic                inbus_re,
  output logic [INBUS_DW-1:0] inbus_data,
  input  logic [INBUS_DW-1:0] rx_byte,
  input  logic                rx_strobe
`ifdef INBUS_RX_IRQ_EN
  ,
  output logic                rx_irq
`endif
);

  logic                phase_q, phase_d;
  logic                ovf_q, ovf_d;
  logic [INBUS_DW-1:0] data_q, data_d;

  logic [INBUS_AW-1:0] offset;
  reg_sel_e            reg_sel;
  logic                first_phase;
  logic                pop;
  logic                push;
  logic                drop;
  logic                status_clr;
  logic [INBUS_DW-1:0] status_val;
  logic [INBUS_DW-1:0] count_val;
  logic [INBUS_DW-1:0] rd_val;

  logic [INBUS_DW-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [AW:0]         fifo_count;

  inbus_rx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (rx_byte),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign offset      = inbus_addr - BASE;
  assign first_phase = inbus_re & ~phase_q;

  // Address decode; the lower-bound test keeps addresses below BASE from
  // aliasing through the wrapped subtraction.
  always_comb begin
    reg_sel = REG_NONE;
    if (inbus_addr >= BASE) begin
      case (offset)
        8'd0:    reg_sel = REG_DATA;
        8'd1:    reg_sel = REG_STATUS;
        8'd2:    reg_sel = REG_COUNT;
        default: reg_sel = REG_NONE;
      endcase
    end
  end

  // Side effects only on the first cycle of an access; an empty DATA read
  // pops nothing. A pop frees a slot for a same-cycle push even when full.
  assign pop        = first_phase & (reg_sel == REG_DATA) & ~fifo_empty;
  assign status_clr = first_phase & (reg_sel == REG_STATUS);
  assign push       = rx_strobe & (~fifo_full | pop);
  assign drop       = rx_strobe & fifo_full & ~pop;

  // Register values as presented on the bus.
  always_comb begin
    status_val              = '0;
    status_val[ST_NONEMPTY] = ~fifo_empty;
    status_val[ST_FULL]     = fifo_full;
    status_val[ST_OVF]      = ovf_q;
    count_val               = count_to_byte(16'(fifo_count));
    case (reg_sel)
      REG_DATA:   rd_val = fifo_empty ? 8'h00 : fifo_head;
      REG_STATUS: rd_val = status_val;
      REG_COUNT:  rd_val = count_val;
      default:    rd_val = 8'h00;
    endcase
  end

  // Next state: phase alternates while re is held, overflow set beats clear,
  // and the bus data register only changes at the start of an access.
  always_comb begin
    phase_d = inbus_re ? ~phase_q : 1'b0;
    ovf_d   = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (status_clr) begin
      ovf_d = 1'b0;
    end
    data_d = first_phase ? rd_val : data_q;
  end

  // Access phase, overflow flag and read-data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      phase_q <= phase_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

  assign inbus_data = data_q;

`ifdef INBUS_RX_IRQ_EN
  logic irq_q;

  // Interrupt request follows "data waiting or bytes lost", one cycle late.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ~fifo_empty | ovf_q;
    end
  end

  assign rx_irq = irq_q;
`endif

endmodule
